// File: rtl/btn_step_gen_pkg.sv
// Shared definitions for the button step-pulse generator: FSM state and
// step-direction encodings plus default timing for a 50 MHz board clock.
package btn_step_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_REPEAT  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    localparam int unsigned DEF_DEBOUNCE_CYC     = 500000;
    localparam int unsigned DEF_REPEAT_DELAY_CYC = 25000000;
    localparam int unsigned DEF_REPEAT_RATE_CYC  = 5000000;
    localparam int unsigned DEF_CNT_W            = 25;

endpackage

// File: rtl/btn_step_gen_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one button.
// Ports:
//   clk, reset  - system clock, async active-high reset
//   btn_raw     - raw asynchronous button pin
//   db          - debounced level (registered)
module btn_step_gen_debounce
    import btn_step_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic db
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Level flips only after DEBOUNCE_CYC consecutive differing samples.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                db_d  = ~db_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/btn_step_gen.sv
// Turns two raw push-buttons into single-cycle up/down step pulses with
// press-and-hold auto-repeat, for editing the sec/min BCD counters.
// Ports:
//   clk, reset                - system clock, async active-high reset
//   btn_up_raw, btn_down_raw  - raw asynchronous button pins
//   enable                    - 1 = edit mode, pulses allowed
//   up, down                  - one-cycle step pulses (never both)
//   held                      - high while a button is in auto-repeat hold
module btn_step_gen
    import btn_step_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int unsigned REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC,
    parameter int unsigned CNT_W            = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    input  logic enable,
    output logic up,
    output logic down,
    output logic held
);

    logic db_up, db_dn;
    logic db_up_dly_q, db_dn_dly_q;
    logic rise_up, rise_dn;
    logic dir_btn, other_btn;

    state_e           state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             up_q, up_d;
    logic             down_q, down_d;
    logic             held_q, held_d;

    btn_step_gen_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) u_db_up (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_up_raw),
        .db      (db_up)
    );

    btn_step_gen_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) u_db_dn (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_down_raw),
        .db      (db_dn)
    );

    assign rise_up   = db_up & ~db_up_dly_q;
    assign rise_dn   = db_dn & ~db_dn_dly_q;
    assign dir_btn   = (dir_q == DIR_UP) ? db_up : db_dn;
    assign other_btn = (dir_q == DIR_UP) ? db_dn : db_up;

    // Next-state, repeat timer and pulse generation.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        // held lags the state by one cycle so it rises after the first pulse
        held_d  = (state_q == ST_DELAY) || (state_q == ST_REPEAT);

        if (!enable) begin
            state_d = (db_up || db_dn) ? ST_LOCKOUT : ST_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timer_d = '0;
                    if (db_up && db_dn) begin
                        state_d = ST_LOCKOUT;
                    end else if (rise_up) begin
                        up_d    = 1'b1;
                        dir_d   = DIR_UP;
                        state_d = ST_DELAY;
                    end else if (rise_dn) begin
                        down_d  = 1'b1;
                        dir_d   = DIR_DN;
                        state_d = ST_DELAY;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    // exits win over a timer expiry landing on the same cycle
                    if (other_btn) begin
                        state_d = ST_LOCKOUT;
                        timer_d = '0;
                    end else if (!dir_btn) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else if ((state_q == ST_DELAY &&
                                  timer_q == CNT_W'(REPEAT_DELAY_CYC - 1)) ||
                                 (state_q == ST_REPEAT &&
                                  timer_q == CNT_W'(REPEAT_RATE_CYC - 1))) begin
                        up_d    = (dir_q == DIR_UP);
                        down_d  = (dir_q == DIR_DN);
                        state_d = ST_REPEAT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                ST_LOCKOUT: begin
                    timer_d = '0;
                    if (!db_up && !db_dn) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_UP;
            timer_q     <= '0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            held_q      <= 1'b0;
            db_up_dly_q <= 1'b0;
            db_dn_dly_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            timer_q     <= timer_d;
            up_q        <= up_d;
            down_q      <= down_d;
            held_q      <= held_d;
            db_up_dly_q <= db_up;
            db_dn_dly_q <= db_dn;
        end
    end

    assign up   = up_q;
    assign down = down_q;
    assign held = held_q;

endmodule

// File: tb/tb_btn_step_gen.sv
// Bench for btn_step_gen: directed scenarios plus random button/enable/reset
// activity, every cycle compared with a press-episode reference model.
module tb_btn_step_gen;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RR = 5;
    localparam int unsigned CW = 25;

    logic clk = 1'b0;
    logic reset;
    logic btn_up_raw;
    logic btn_down_raw;
    logic enable;
    logic up, down, held;

    always #5 clk = ~clk;

    btn_step_gen #(
        .DEBOUNCE_CYC     (DB),
        .REPEAT_DELAY_CYC (RD),
        .REPEAT_RATE_CYC  (RR),
        .CNT_W            (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_up_raw   (btn_up_raw),
        .btn_down_raw (btn_down_raw),
        .enable       (enable),
        .up           (up),
        .down         (down),
        .held         (held)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw sample history, debounced levels, press episode.
    bit hu [0:DB];
    bit hd [0:DB];
    bit m_dbu, m_dbd, m_dbu_q, m_dbd_q;
    int m_act;      // 0 none, 1 up held, 2 down held
    bit m_lock;
    int m_cnt;      // cycles since the first pulse of the current press
    bit e_up, e_dn, e_held;

    int cyc = 0;
    int n_up, n_dn;
    int first_up, first_dn;

    function automatic bit pulse_due(input int c);
        return (c == int'(RD)) || (c > int'(RD) && ((c - int'(RD)) % int'(RR)) == 0);
    endfunction

    task automatic model_clear();
        for (int i = 0; i <= int'(DB); i++) begin
            hu[i] = 1'b0;
            hd[i] = 1'b0;
        end
        m_dbu = 0; m_dbd = 0; m_dbu_q = 0; m_dbd_q = 0;
        m_act = 0; m_lock = 0; m_cnt = 0;
        e_up = 0; e_dn = 0; e_held = 0;
    endtask

    task automatic model_edge();
        bit mine, other, diff_u, diff_d;
        if (reset) begin
            model_clear();
            return;
        end
        e_up = 0; e_dn = 0;
        e_held = (m_act != 0);
        if (!enable) begin
            m_act  = 0;
            m_lock = m_dbu | m_dbd;
        end else if (m_lock) begin
            if (!m_dbu && !m_dbd) m_lock = 0;
        end else if (m_act != 0) begin
            mine  = (m_act == 1) ? m_dbu : m_dbd;
            other = (m_act == 1) ? m_dbd : m_dbu;
            if (other) begin
                m_act = 0; m_lock = 1;
            end else if (!mine) begin
                m_act = 0;
            end else begin
                m_cnt++;
                if (pulse_due(m_cnt)) begin
                    if (m_act == 1) e_up = 1; else e_dn = 1;
                end
            end
        end else begin
            if (m_dbu && m_dbd) m_lock = 1;
            else if (m_dbu && !m_dbu_q) begin m_act = 1; m_cnt = 0; e_up = 1; end
            else if (m_dbd && !m_dbd_q) begin m_act = 2; m_cnt = 0; e_dn = 1; end
        end
        // debounced level flips once the synchronised input has differed
        // from it for DB consecutive samples (synchroniser = 2 samples late)
        m_dbu_q = m_dbu;
        m_dbd_q = m_dbd;
        diff_u = 1; diff_d = 1;
        for (int i = 1; i <= int'(DB); i++) begin
            if (hu[i] == m_dbu) diff_u = 0;
            if (hd[i] == m_dbd) diff_d = 0;
        end
        if (diff_u) m_dbu = ~m_dbu;
        if (diff_d) m_dbd = ~m_dbd;
        for (int i = int'(DB); i >= 1; i--) begin
            hu[i] = hu[i-1];
            hd[i] = hd[i-1];
        end
        hu[0] = btn_up_raw;
        hd[0] = btn_down_raw;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check("up", up, e_up);
        check("down", down, e_dn);
        check("held", held, e_held);
        if (up === 1'b1) begin
            n_up++;
            if (first_up < 0) first_up = cyc;
        end
        if (down === 1'b1) begin
            n_dn++;
            if (first_dn < 0) first_dn = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic mark();
        n_up = 0; n_dn = 0; first_up = -1; first_dn = -1;
    endtask

    int e0;

    initial begin
        model_clear();
        mark();
        reset = 1'b1; btn_up_raw = 1'b0; btn_down_raw = 1'b0; enable = 1'b1;
        run(3);
        reset = 1'b0;
        run(5);

        // 1: clean press, pulse DB+3 edges after the raw edge
        mark(); e0 = cyc;
        btn_up_raw = 1'b1; run(8);
        btn_up_raw = 1'b0; run(12);
        check("s1_up_count", n_up, 1);
        check("s1_latency", first_up - e0, DB + 3);
        check("s1_down_count", n_dn, 0);

        // 2: bounce then settle, and a short glitch
        mark();
        for (int i = 0; i < 3; i++) begin
            btn_up_raw = 1'b1; run(2);
            btn_up_raw = 1'b0; run(2);
        end
        e0 = cyc;
        btn_up_raw = 1'b1; run(15);
        btn_up_raw = 1'b0; run(12);
        check("s2_up_count", n_up, 1);
        check("s2_latency", first_up - e0, DB + 3);
        mark();
        btn_up_raw = 1'b1; run(3);
        btn_up_raw = 1'b0; run(12);
        check("s2_glitch", n_up + n_dn, 0);

        // 3: hold down for 60 cycles -> first pulse plus 8 repeats
        mark(); e0 = cyc;
        btn_down_raw = 1'b1; run(60);
        btn_down_raw = 1'b0; run(15);
        check("s3_down_count", n_dn, 9);
        check("s3_latency", first_dn - e0, DB + 3);
        check("s3_up_count", n_up, 0);

        // 4: both buttons -> lockout until everything is released
        mark();
        btn_up_raw = 1'b1; run(10);
        btn_down_raw = 1'b1; run(30);
        btn_down_raw = 1'b0; run(15);
        btn_up_raw = 1'b0; run(10);
        btn_up_raw = 1'b1; run(10);
        btn_up_raw = 1'b0; run(12);
        check("s4_up_count", n_up, 2);
        check("s4_down_count", n_dn, 0);

        // 5: enable dropped while held, re-raised with button still held
        mark();
        btn_up_raw = 1'b1; run(DB + 3 + 5);
        enable = 1'b0; run(30);
        enable = 1'b1; run(30);
        btn_up_raw = 1'b0; run(10);
        btn_up_raw = 1'b1; run(10);
        btn_up_raw = 1'b0; run(12);
        check("s5_up_count", n_up, 2);

        // 6: reset during REPEAT clears outputs at once, then restarts
        btn_down_raw = 1'b1; run(40);
        check("s6_held_before", held, 1);
        reset = 1'b1;
        #1;
        check("s6_rst_up", up, 0);
        check("s6_rst_down", down, 0);
        check("s6_rst_held", held, 0);
        run(3);
        mark(); e0 = cyc;
        reset = 1'b0;
        run(12);
        check("s6_latency", first_dn - e0, DB + 3);
        check("s6_down_count", n_dn, 1);
        btn_down_raw = 1'b0; run(12);

        // random phase: slow button levels with bounce, rare enable/reset
        begin
            bit tu, td;
            tu = 0; td = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 39) == 0) tu = ~tu;
                if ($urandom_range(0, 39) == 0) td = ~td;
                btn_up_raw   = ($urandom_range(0, 5) == 0) ? ~tu : tu;
                btn_down_raw = ($urandom_range(0, 5) == 0) ? ~td : td;
                if ($urandom_range(0, 299) == 0) enable = ~enable;
                reset = ($urandom_range(0, 999) == 0);
                step();
            end
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
